buffer_if_id_riesgos: RTL and testbench
=======================================

Name: buffer_if_id_riesgos

Overview:
- IF/ID pipeline register with integrated hazard detection.
- Sits directly upstream of the ID/EX buffer: captures PC+4 and the fetched instruction, and presents them to decode.
- Uses feedback from the ID/EX stage outputs to freeze PC and IF/ID, and to inject a control bubble into ID/EX on load-use and branch-operand hazards.
- Squashes the fetched instruction on a taken branch or jump.

Parameters:
- ANCHO, 32, width of PC+4 and instruction words.
- NOP, 32'h00000000, instruction value loaded on flush or reset.
- ANCHO_CNT, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- EnPC4  input  ANCHO  PC+4 from the fetch stage.
- EnIns  input  ANCHO  instruction from instruction memory.
- EnFlush  input  1  taken branch or jump resolved in ID; squash the fetched instruction.
- EnMemRead  input  1  MemRead bit of the instruction currently in ID/EX.
- EnRegWrite  input  1  RegWrite bit of the instruction currently in ID/EX.
- EnDest  input  5  destination register of the instruction in ID/EX (after RegDst selection).
- SalPC4  output  ANCHO  registered PC+4 to decode.
- SalIns  output  ANCHO  registered instruction to decode.
- SalValido  output  1  SalIns holds a real (non-squashed) instruction.
- PCWrite  output  1  combinational; 0 freezes the PC.
- Burbuja  output  1  combinational; 1 forces all WB/M/EX control entering ID/EX to zero.
- CntStall  output  ANCHO_CNT  saturating count of stall cycles since reset.

Behaviour:
- Field decode from SalIns: op = [31:26], rs = [25:21], rt = [20:16].
- match = (EnDest != 0) && (EnDest == rs || EnDest == rt). This is conservative: both rs and rt are checked for every opcode except J (op 000010), which never matches.
- Hazard detection is evaluated only when state = RUN and SalValido = 1.
  - Load-use: EnMemRead && match. Requires 2 stall cycles if op = beq (000100), otherwise 1.
  - ALU-to-branch: EnRegWrite && !EnMemRead && match && op = beq. Requires 1 stall cycle.
- State machine: RUN, STALL.
  - A stall counter `pend` (2 bits) is loaded with (required − 1) on detection.
  - RUN → STALL when a 2-stall hazard is detected; `pend` = 1.
  - STALL → RUN after one more stall cycle; `pend` = 0.
  - A 1-stall hazard stays in RUN. The next cycle re-evaluates naturally, because the ID/EX content is then a bubble.
- stall = hazard detected this cycle, OR state = STALL.
- Combinational outputs:
  - PCWrite = !stall.
  - Burbuja = stall.
- Register update on each rising edge, by priority:
  - stall: SalPC4, SalIns and SalValido hold. EnFlush is ignored, because the stalled branch has not resolved.
  - else EnFlush: SalPC4 <= EnPC4, SalIns <= NOP, SalValido <= 0.
  - else: SalPC4 <= EnPC4, SalIns <= EnIns, SalValido <= 1.
- Latency: 1 cycle from EnIns to SalIns when not stalled.
- CntStall increments on every cycle where stall = 1, and saturates at all-ones (no wrap).
- Reset (rst_n = 0, asynchronous, takes effect immediately even mid-stall):
  - Registers: SalPC4 = 0, SalIns = NOP, SalValido = 0, state = RUN, `pend` = 0, CntStall = 0.
  - Combinational outputs while in reset: PCWrite = 1, Burbuja = 0.
- After reset release, the first edge loads EnIns normally.
- No hazard is raised while SalValido = 0. A NOP (all fields 0) never matches because EnDest = 0 is excluded.

Test Plan:
- Reset mid-STALL:
  - Stimulus: assert rst_n = 0 during a 2-cycle stall.
  - Response: SalIns = 0, SalValido = 0, CntStall = 0, PCWrite = 1 immediately. The next edge after release loads EnIns.
- Load-use, ALU consumer:
  - Stimulus: SalIns = add $3,$2,$4 (0x00441820), EnMemRead = 1, EnDest = 2.
  - Response: exactly 1 cycle with PCWrite = 0 and Burbuja = 1, SalIns held. Then normal advance; CntStall = 1.
- Load then beq:
  - Stimulus: SalIns = beq $2,$5,… (0x10450003), EnMemRead = 1, EnDest = 2, with EnMemRead = 0 on the following cycle.
  - Response: 2 consecutive stall cycles (state passes through STALL), then advance; CntStall = 2.
- ALU then beq:
  - Stimulus: EnRegWrite = 1, EnMemRead = 0, EnDest = 5, same beq.
  - Response: 1 stall cycle.
  - Stimulus: same, but with EnDest = 0.
  - Response: no stall.
- Flush vs stall:
  - Stimulus: EnFlush = 1 with no hazard.
  - Response: next SalIns = 0, SalValido = 0, SalPC4 = EnPC4, and no hazard raised the following cycle.
  - Stimulus: EnFlush = 1 during a stall.
  - Response: ignored; registers hold.
- Saturation:
  - Stimulus: with ANCHO_CNT = 4, force 20 stall cycles.
  - Response: CntStall stops at 15.

Source files
------------

// File: rtl/buffer_if_id_riesgos_if.sv
// -----------------------------------------------------------------------------
// buffer_if_id_riesgos_if
// Bus between the fetch/ID-EX side and the IF/ID buffer with hazard detection.
//   Inputs to the buffer : EnPC4, EnIns, EnFlush, EnMemRead, EnRegWrite, EnDest
//   Outputs of the buffer: SalPC4, SalIns, SalValido, PCWrite, Burbuja, CntStall
// Modports:
//   slave  - the buffer itself (consumes En*, drives Sal*/PCWrite/Burbuja/CntStall)
//   master - the surrounding pipeline (drives En*, observes the rest)
// -----------------------------------------------------------------------------
interface buffer_if_id_riesgos_if #(
   parameter int ANCHO     = 32,
   parameter int ANCHO_CNT = 16
);
   logic [ANCHO-1:0]     EnPC4;
   logic [ANCHO-1:0]     EnIns;
   logic                 EnFlush;
   logic                 EnMemRead;
   logic                 EnRegWrite;
   logic [4:0]           EnDest;

   logic [ANCHO-1:0]     SalPC4;
   logic [ANCHO-1:0]     SalIns;
   logic                 SalValido;
   logic                 PCWrite;
   logic                 Burbuja;
   logic [ANCHO_CNT-1:0] CntStall;

   modport slave (
      input  EnPC4, EnIns, EnFlush, EnMemRead, EnRegWrite, EnDest,
      output SalPC4, SalIns, SalValido, PCWrite, Burbuja, CntStall
   );

   modport master (
      output EnPC4, EnIns, EnFlush, EnMemRead, EnRegWrite, EnDest,
      input  SalPC4, SalIns, SalValido, PCWrite, Burbuja, CntStall
   );
endinterface

// File: rtl/buffer_if_id_riesgos.sv
// -----------------------------------------------------------------------------
// buffer_if_id_riesgos
// IF/ID pipeline register with integrated hazard detection.
//   - Captures PC+4 and the fetched instruction for decode (1-cycle latency).
//   - Using the ID/EX feedback (MemRead, RegWrite, destination register) it
//     detects load-use and branch-operand hazards, freezes PC and IF/ID
//     (PCWrite = 0) and injects a control bubble into ID/EX (Burbuja = 1).
//   - A load feeding a beq needs two stall cycles, tracked by a RUN/STALL FSM.
//   - A taken branch/jump (EnFlush) squashes the fetched instruction to NOP.
//   - CntStall counts stall cycles since reset, saturating at all-ones.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous reset, active-low
//   bus   - slave side of buffer_if_id_riesgos_if (see that file)
// -----------------------------------------------------------------------------
module buffer_if_id_riesgos #(
   parameter int               ANCHO     = 32,
   parameter logic [ANCHO-1:0] NOP       = '0,
   parameter int               ANCHO_CNT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   buffer_if_id_riesgos_if.slave   bus
);

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } estado_t;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   estado_t              estado_q, estado_d;
   logic [1:0]           pend_q, pend_d;
   logic [ANCHO-1:0]     sal_pc4_q, sal_pc4_d;
   logic [ANCHO-1:0]     sal_ins_q, sal_ins_d;
   logic                 sal_valido_q, sal_valido_d;
   logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

   // Fields of the instruction sitting in decode.
   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;

   logic es_beq;
   logic coincide;
   logic evaluar;
   logic riesgo_carga;
   logic riesgo_alu;
   logic riesgo;
   logic riesgo_doble;
   logic stall;

   assign op = sal_ins_q[31:26];
   assign rs = sal_ins_q[25:21];
   assign rt = sal_ins_q[20:16];

   // ---------------------------------------------------------------------------
   // Hazard detection. Both rs and rt are compared for every opcode (the
   // conservative choice); only J is known to read no registers. $0 never
   // creates a dependency, which also keeps NOPs and bubbles hazard-free.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a value on every path (defaults
      // first), so no latch is inferred.
      es_beq       = 1'b0;
      coincide     = 1'b0;
      evaluar      = 1'b0;
      riesgo_carga = 1'b0;
      riesgo_alu   = 1'b0;
      riesgo       = 1'b0;
      riesgo_doble = 1'b0;
      stall        = 1'b0;

      es_beq   = (op == OP_BEQ);
      coincide = (bus.EnDest != 5'd0) &&
                 ((bus.EnDest == rs) || (bus.EnDest == rt)) &&
                 (op != OP_J);
      // In STALL the outcome is already decided; a squashed slot has nothing
      // to protect.
      evaluar  = (estado_q == RUN) && sal_valido_q;

      riesgo_carga = evaluar && bus.EnMemRead && coincide;
      riesgo_alu   = evaluar && bus.EnRegWrite && !bus.EnMemRead && coincide && es_beq;
      riesgo       = riesgo_carga || riesgo_alu;
      // A load result reaches a branch compare in ID only after two bubbles.
      riesgo_doble = riesgo_carga && es_beq;

      stall = riesgo || (estado_q == STALL);
   end

   // ---------------------------------------------------------------------------
   // FSM next state. pend holds the stall cycles still owed after this one.
   // A 1-stall hazard stays in RUN: next cycle ID/EX holds the bubble we just
   // injected, so detection clears by itself.
   // ---------------------------------------------------------------------------
   always_comb begin
      estado_d = estado_q;
      pend_d   = pend_q;

      unique case (estado_q)
         RUN: begin
            if (riesgo_doble) begin
               estado_d = STALL;
               pend_d   = 2'd1;
            end else if (riesgo) begin
               pend_d = 2'd0;
            end
         end
         STALL: begin
            if (pend_q > 2'd1) begin
               pend_d = pend_q - 2'd1;
            end else begin
               estado_d = RUN;
               pend_d   = 2'd0;
            end
         end
         default: begin
            estado_d = RUN;
            pend_d   = 2'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next state. Stall has priority over flush: a stalled branch has
   // not resolved yet, so any flush request seen now is not meaningful.
   // ---------------------------------------------------------------------------
   always_comb begin
      sal_pc4_d    = sal_pc4_q;
      sal_ins_d    = sal_ins_q;
      sal_valido_d = sal_valido_q;

      if (!stall) begin
         sal_pc4_d = bus.EnPC4;
         if (bus.EnFlush) begin
            sal_ins_d    = NOP;
            sal_valido_d = 1'b0;
         end else begin
            sal_ins_d    = bus.EnIns;
            sal_valido_d = 1'b1;
         end
      end
   end

   // Saturating stall counter: holds at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (stall && !(&cnt_q)) begin
         cnt_d = cnt_q + {{(ANCHO_CNT-1){1'b0}}, 1'b1};
      end
   end

   // ---------------------------------------------------------------------------
   // State registers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: every register here has a reset value; the pipeline must come out of
   // reset with a NOP in decode and no pending stall.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q     <= RUN;
         pend_q       <= 2'd0;
         sal_pc4_q    <= '0;
         sal_ins_q    <= NOP;
         sal_valido_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         estado_q     <= estado_d;
         pend_q       <= pend_d;
         sal_pc4_q    <= sal_pc4_d;
         sal_ins_q    <= sal_ins_d;
         sal_valido_q <= sal_valido_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.SalPC4    = sal_pc4_q;
   assign bus.SalIns    = sal_ins_q;
   assign bus.SalValido = sal_valido_q;
   assign bus.PCWrite   = !stall;
   assign bus.Burbuja   = stall;
   assign bus.CntStall  = cnt_q;

endmodule

// File: tb/tb_buffer_if_id_riesgos.sv
// -----------------------------------------------------------------------------
// tb_buffer_if_id_riesgos
// Directed bench for buffer_if_id_riesgos. A vector table walks the buffer
// through load-use, load->beq, ALU->beq, J and flush cases; hand-written
// sequences cover reset in the middle of a two-cycle stall and saturation of a
// 4-bit stall counter.
// -----------------------------------------------------------------------------
module tb_buffer_if_id_riesgos;

   localparam int ANCHO     = 32;
   localparam int ANCHO_CNT = 4;

   // Instruction encodings used below.
   localparam logic [31:0] I_NOP = 32'h00000000;
   localparam logic [31:0] I_ADD = 32'h00441820; // add $3,$2,$4  rs=2 rt=4
   localparam logic [31:0] I_BEQ = 32'h10450003; // beq $2,$5,3   rs=2 rt=5
   localparam logic [31:0] I_OR  = 32'h00E83025; // or  $6,$7,$8  rs=7 rt=8
   localparam logic [31:0] I_J   = 32'h08420000; // j, index bits look like rs=2 rt=2

   logic clk;
   logic rst_n;

   buffer_if_id_riesgos_if #(.ANCHO(ANCHO), .ANCHO_CNT(ANCHO_CNT)) bus ();

   buffer_if_id_riesgos #(
      .ANCHO     (ANCHO),
      .NOP       (I_NOP),
      .ANCHO_CNT (ANCHO_CNT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        mr;
      logic        rw;
      logic [4:0]  dest;
      logic [31:0] pc4;
      logic [31:0] ins;
      logic        pw;     // expected PCWrite before the edge
      logic        bb;     // expected Burbuja before the edge
      logic [31:0] e_pc4;  // expected registers after the edge
      logic [31:0] e_ins;
      logic        e_val;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl [16];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic flush, logic mr, logic rw, logic [4:0] dest,
                               logic [31:0] pc4, logic [31:0] ins,
                               logic pw, logic bb, logic [31:0] e_pc4,
                               logic [31:0] e_ins, logic e_val, logic [3:0] e_cnt);
      vec_t v;
      v.flush = flush; v.mr = mr; v.rw = rw; v.dest = dest;
      v.pc4 = pc4; v.ins = ins; v.pw = pw; v.bb = bb;
      v.e_pc4 = e_pc4; v.e_ins = e_ins; v.e_val = e_val; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic flush, input logic mr, input logic rw,
                        input logic [4:0] dest, input logic [31:0] pc4, input logic [31:0] ins);
      bus.EnFlush    = flush;
      bus.EnMemRead  = mr;
      bus.EnRegWrite = rw;
      bus.EnDest     = dest;
      bus.EnPC4      = pc4;
      bus.EnIns      = ins;
   endtask

   // Watchdog: the bench must always end by itself.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //              fl mr rw dst pc4    ins    pw bb e_pc4  e_ins  val cnt
      tbl[0]  = mk(0, 0, 0, 0, 32'd4,  I_ADD, 1, 0, 32'd4,  I_ADD, 1, 0); // first load after reset
      tbl[1]  = mk(0, 1, 0, 2, 32'd8,  I_OR,  0, 1, 32'd4,  I_ADD, 1, 1); // load-use on rs: 1 stall
      tbl[2]  = mk(0, 0, 0, 0, 32'd8,  I_OR,  1, 0, 32'd8,  I_OR,  1, 1); // bubble in ID/EX: advance
      tbl[3]  = mk(0, 0, 1, 9, 32'd12, I_BEQ, 1, 0, 32'd12, I_BEQ, 1, 1); // unrelated writer
      tbl[4]  = mk(0, 1, 0, 2, 32'd16, I_ADD, 0, 1, 32'd12, I_BEQ, 1, 2); // load -> beq: enter STALL
      tbl[5]  = mk(1, 0, 0, 0, 32'd16, I_ADD, 0, 1, 32'd12, I_BEQ, 1, 3); // 2nd stall, flush ignored
      tbl[6]  = mk(0, 0, 0, 0, 32'd16, I_ADD, 1, 0, 32'd16, I_ADD, 1, 3); // back to RUN, advance
      tbl[7]  = mk(0, 0, 0, 0, 32'd20, I_BEQ, 1, 0, 32'd20, I_BEQ, 1, 3);
      tbl[8]  = mk(0, 0, 1, 5, 32'd24, I_OR,  0, 1, 32'd20, I_BEQ, 1, 4); // ALU -> beq on rt: 1 stall
      tbl[9]  = mk(0, 0, 1, 0, 32'd24, I_OR,  1, 0, 32'd24, I_OR,  1, 4); // EnDest = $0: no stall
      tbl[10] = mk(1, 0, 0, 0, 32'd28, I_J,   1, 0, 32'd28, I_NOP, 0, 4); // flush: squash
      tbl[11] = mk(0, 1, 0, 2, 32'd32, I_ADD, 1, 0, 32'd32, I_ADD, 1, 4); // squashed slot: no hazard
      tbl[12] = mk(0, 0, 1, 4, 32'd36, I_J,   1, 0, 32'd36, I_J,   1, 4); // ALU -> non-branch: none
      tbl[13] = mk(0, 1, 0, 2, 32'd40, I_ADD, 1, 0, 32'd40, I_ADD, 1, 4); // J never matches
      tbl[14] = mk(0, 1, 0, 4, 32'd44, I_OR,  0, 1, 32'd40, I_ADD, 1, 5); // load-use on rt
      tbl[15] = mk(0, 0, 0, 0, 32'd44, I_OR,  1, 0, 32'd44, I_OR,  1, 5);

      // Reset state.
      rst_n = 1'b0;
      drive(0, 0, 0, 5'd0, 32'd0, 32'd0);
      #1;
      check("reset SalPC4",    bus.SalPC4,    32'd0);
      check("reset SalIns",    bus.SalIns,    I_NOP);
      check("reset SalValido", bus.SalValido, 32'd0);
      check("reset CntStall",  bus.CntStall,  32'd0);
      check("reset PCWrite",   bus.PCWrite,   32'd1);
      check("reset Burbuja",   bus.Burbuja,   32'd0);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(tbl[i].flush, tbl[i].mr, tbl[i].rw, tbl[i].dest, tbl[i].pc4, tbl[i].ins);
         #1;
         check($sformatf("v%0d PCWrite", i), bus.PCWrite, tbl[i].pw);
         check($sformatf("v%0d Burbuja", i), bus.Burbuja, tbl[i].bb);
         @(posedge clk);
         #1;
         check($sformatf("v%0d SalPC4", i),    bus.SalPC4,    tbl[i].e_pc4);
         check($sformatf("v%0d SalIns", i),    bus.SalIns,    tbl[i].e_ins);
         check($sformatf("v%0d SalValido", i), bus.SalValido, tbl[i].e_val);
         check($sformatf("v%0d CntStall", i),  bus.CntStall,  tbl[i].e_cnt);
      end

      // Reset in the middle of a two-cycle load -> beq stall.
      @(negedge clk);
      drive(0, 0, 0, 5'd0, 32'd48, I_BEQ);
      @(negedge clk);
      drive(0, 1, 0, 5'd2, 32'd52, I_ADD);
      @(posedge clk);
      #1;
      check("midstall PCWrite", bus.PCWrite, 32'd0);
      check("midstall SalIns",  bus.SalIns,  I_BEQ);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst mid-stall SalIns",    bus.SalIns,    I_NOP);
      check("rst mid-stall SalValido", bus.SalValido, 32'd0);
      check("rst mid-stall CntStall",  bus.CntStall,  32'd0);
      check("rst mid-stall PCWrite",   bus.PCWrite,   32'd1);
      check("rst mid-stall Burbuja",   bus.Burbuja,   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 5'd0, 32'd100, I_ADD);
      @(posedge clk);
      #1;
      check("post-reset SalIns",    bus.SalIns,    I_ADD);
      check("post-reset SalPC4",    bus.SalPC4,    32'd100);
      check("post-reset SalValido", bus.SalValido, 32'd1);
      check("post-reset CntStall",  bus.CntStall,  32'd0);

      // Saturation: a load to $2 that never leaves ID/EX stalls every cycle.
      @(negedge clk);
      drive(0, 1, 0, 5'd2, 32'd104, I_OR);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 14) check("sat CntStall@14", bus.CntStall, 32'd14);
         if (k == 15) check("sat CntStall@15", bus.CntStall, 32'd15);
      end
      check("sat CntStall@20", bus.CntStall, 32'd15);
      check("sat SalIns held", bus.SalIns,   I_ADD);
      check("sat PCWrite",     bus.PCWrite,  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
